// File: rtl/broj_u_kodove.sv
// broj_u_kodove: binary to BCD via double dabble, then streams the decimal digits MSD-first as PS/2 set-2 make codes
// Ports:
//    clk, reset               rising-edge clock, synchronous active-high reset
//    start, bin_in            conversion request (taken only when idle) and the value to convert
//    busy, done               busy from the cycle after start until the final handshake, done pulses once after it
//    bcd_out                  packed BCD result, digit 0 in [3:0]
//    code_valid, code_ready   handshake for key_code
//    key_code, code_last      make code of the current digit, flag on the final (units) digit
module broj_u_kodove #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  code_valid,
   input  logic                  code_ready,
   output logic [7:0]            key_code,
   output logic                  code_last
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int PW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   typedef enum logic [1:0] {IDLE, CONV, EMIT} state_t;
   state_t state, state_n;
   logic [WIDTH-1:0] sr;
   logic [4*DIGITS-1:0] acc, acc_adj, acc_n;
   logic [CW-1:0] cnt;
   logic [PW-1:0] ptr, msd;
   logic [3:0] digit;
   logic [7:0] make;
   logic last;
   always_comb begin
      acc_adj = acc;
      for (int i = 0; i < DIGITS; i++)
         acc_adj[4*i+:4] = acc[4*i+:4] >= 4'd5 ? acc[4*i+:4] + 4'd3 : acc[4*i+:4];
      acc_n = {acc_adj[4*DIGITS-2:0], sr[WIDTH-1]};
      // highest nonzero digit of the finished result; stays 0 for a zero value so one '0' is emitted
      msd = '0;
      for (int i = 0; i < DIGITS; i++)
         if (acc_n[4*i+:4] != 4'd0) msd = PW'(i);
   end
   assign last       = state == CONV && cnt == CW'(WIDTH - 1);
   assign busy       = state != IDLE;
   assign code_valid = state == EMIT;
   assign code_last  = code_valid && ptr == '0;
   assign digit      = bcd_out[4*ptr+:4];
   always_comb begin
      case (digit)
         4'd0:    make = 8'h45;
         4'd1:    make = 8'h16;
         4'd2:    make = 8'h1E;
         4'd3:    make = 8'h26;
         4'd4:    make = 8'h25;
         4'd5:    make = 8'h2E;
         4'd6:    make = 8'h36;
         4'd7:    make = 8'h3D;
         4'd8:    make = 8'h3E;
         4'd9:    make = 8'h46;
         default: make = 8'h00;
      endcase
      key_code = code_valid ? make : 8'h00;
   end
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = start ? CONV : IDLE;
         CONV:    state_n = last ? EMIT : CONV;
         EMIT:    state_n = code_ready && code_last ? IDLE : EMIT;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         sr      <= '0;
         acc     <= '0;
         cnt     <= '0;
         ptr     <= '0;
         bcd_out <= '0;
         done    <= 1'b0;
      end else begin
         state <= state_n;
         done  <= code_valid && code_ready && code_last;
         case (state)
            IDLE: if (start) begin
               sr  <= bin_in;
               acc <= '0;
               cnt <= '0;
            end
            CONV: begin
               sr  <= {sr[WIDTH-2:0], 1'b0};
               acc <= acc_n;
               cnt <= cnt + CW'(1);
               if (last) begin
                  bcd_out <= acc_n;
                  ptr     <= msd;
               end
            end
            EMIT: if (code_ready && !code_last) ptr <= ptr - PW'(1);
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_broj_u_kodove.sv
// tb_broj_u_kodove: randomized and directed self-checking bench for broj_u_kodove against a decimal-digit model
module tb_broj_u_kodove;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0, code_ready = 1'b1;
   logic [15:0] bin_in = '0;
   logic busy, done, code_valid, code_last;
   logic [19:0] bcd_out;
   logic [7:0] key_code;
   logic [7:0] kc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
   int checks = 0, errors = 0;
   broj_u_kodove #(.WIDTH(16), .DIGITS(5)) dut (
      .clk(clk), .reset(reset), .start(start), .bin_in(bin_in), .busy(busy), .done(done),
      .bcd_out(bcd_out), .code_valid(code_valid), .code_ready(code_ready), .key_code(key_code),
      .code_last(code_last)
   );
   always #5 clk = ~clk;
   // Starts a conversion of v at the current negedge and ends on the negedge of the done cycle.
   // stall: cycles code_ready is held low before each handshake; poke: fire a stray start (bin_in=7) mid-CONV.
   task automatic convert(input logic [15:0] v, input int stall, input bit poke);
      int q[$];
      int n;
      logic [19:0] eb;
      n = v;
      do begin q.push_front(n % 10); n = n / 10; end while (n > 0);
      eb = '0;
      foreach (q[i]) eb = (eb << 4) | 20'(q[i]);
      bin_in = v;
      start = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, code_valid, done} !== 3'b100) begin
         errors++;
         $display("FAIL start_accept v=%0d: busy/valid/done=%b required 100", v, {busy, code_valid, done});
      end
      for (int c = 1; c <= 16; c++) begin
         code_ready = 1'($urandom);
         start = poke && c == 5;
         if (start) bin_in = 16'd7;
         @(negedge clk);
      end
      start = 1'b0;
      bin_in = 16'($urandom);
      checks++;
      if (bcd_out !== eb) begin
         errors++;
         $display("FAIL bcd_out v=%0d: got %h required %h", v, bcd_out, eb);
      end
      foreach (q[k]) begin
         for (int s = 0; s <= stall; s++) begin
            code_ready = s == stall;
            checks++;
            if ({code_valid, key_code, code_last, done, busy} !== {1'b1, kc[q[k]], k == q.size() - 1, 1'b0, 1'b1}) begin
               errors++;
               $display("FAIL emit v=%0d digit %0d: valid=%b code=%h last=%b done=%b busy=%b required valid=1 code=%h last=%b done=0 busy=1",
                        v, k, code_valid, key_code, code_last, done, busy, kc[q[k]], k == q.size() - 1);
            end
            @(negedge clk);
         end
      end
      checks++;
      if ({done, busy, code_valid, code_last, key_code} !== 12'b1000_0000_0000) begin
         errors++;
         $display("FAIL done_cycle v=%0d: done=%b busy=%b valid=%b last=%b code=%h required done=1 others 0",
                  v, done, busy, code_valid, code_last, key_code);
      end
   endtask
   task automatic test_reset;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, code_valid, code_last, key_code, bcd_out} !== 32'd0) begin
         errors++;
         $display("FAIL reset_values: busy=%b done=%b valid=%b last=%b code=%h bcd=%h required all 0",
                  busy, done, code_valid, code_last, key_code, bcd_out);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask
   task automatic test_directed;
      logic [15:0] vals [4] = '{16'd1234, 16'd0, 16'd65535, 16'd1000};
      foreach (vals[i]) begin
         convert(vals[i], 0, 1'b0);
         @(negedge clk);
         checks++;
         if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_width v=%0d: done=%b required 0", vals[i], done);
         end
      end
   endtask
   task automatic test_backpressure;
      convert(16'd89, 3, 1'b0);
      @(negedge clk);
   endtask
   task automatic test_ignore_start;
      convert(16'd55, 0, 1'b1);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL stray_start_queued: busy=%b required 0", busy);
      end
   endtask
   task automatic test_back_to_back;
      convert(16'd300, 0, 1'b0);
      convert(16'd4096, 1, 1'b0);
      @(negedge clk);
   endtask
   task automatic test_abort;
      for (int p = 0; p < 2; p++) begin
         bin_in = 16'd1234;
         start = 1'b1;
         code_ready = 1'b0;
         @(negedge clk);
         start = 1'b0;
         repeat (p == 0 ? 5 : 17) @(negedge clk);
         if (p == 1) begin
            checks++;
            if ({code_valid, key_code, bcd_out} !== {1'b1, 8'h16, 20'h01234}) begin
               errors++;
               $display("FAIL abort_pre_emit: valid=%b code=%h bcd=%h required 1 16 01234", code_valid, key_code, bcd_out);
            end
         end
         reset = 1'b1;
         @(negedge clk);
         checks++;
         if ({busy, done, code_valid, code_last, key_code, bcd_out} !== 32'd0) begin
            errors++;
            $display("FAIL abort_phase%0d: busy=%b done=%b valid=%b last=%b code=%h bcd=%h required all 0",
                     p, busy, done, code_valid, code_last, key_code, bcd_out);
         end
         reset = 1'b0;
         code_ready = 1'b1;
         repeat (3) begin
            @(negedge clk);
            checks++;
            if ({busy, done} !== 2'b00) begin
               errors++;
               $display("FAIL abort_idle%0d: busy=%b done=%b required 00", p, busy, done);
            end
         end
      end
      convert(16'd907, 0, 1'b0);
      @(negedge clk);
   endtask
   task automatic test_random;
      for (int i = 0; i < 25; i++) begin
         convert(16'($urandom), int'($urandom_range(0, 2)), 1'b0);
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
      @(negedge clk);
   endtask
   initial begin
      test_reset;
      test_directed;
      test_backpressure;
      test_ignore_start;
      test_back_to_back;
      test_abort;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
